// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port sequencer: the
// sequencer state encoding and the default register-file geometry.
package regfile_port_arbiter_pkg;

  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  // INIT sweeps zeros, RUN arbitrates core vs debug, DBG is the forced debug slot
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2
  } fsm_t;

endpackage

// File: rtl/sat_wait_counter.sv
// Aging counter for a pending debug write: counts consecutive cycles the
// request loses to the core and flags when the next loss must be the last.
module sat_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic startin_n,
  input  logic inc,
  output logic at_limit
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] TOP   = WW'(MAX_WAIT);

  logic [WW-1:0] wcnt;

  // Count losses while inc is held, saturating at MAX_WAIT; any other cycle clears
  always_ff @(posedge clk or negedge startin_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!startin_n) begin
      wcnt <= '0;
    end else if (!inc) begin
      wcnt <= '0;
    end else if (wcnt != TOP) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign at_limit = (wcnt == LIMIT);

endmodule

// File: rtl/regfile_port_arbiter.sv
// Owner of the register file's single write port: zero-fills r1..r(NREG-1)
// after reset or soft_init, then shares the port between core writeback
// (priority) and a debug requester that is forced through after MAX_WAIT losses.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          startin_n,
  input  logic          soft_init,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          busy,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

  fsm_t          fsm, fsm_next;
  logic [AW-1:0] idx, idx_next;
  logic          init_pend, init_pend_next;

  logic core_eff;
  logic wait_inc;
  logic wait_at_limit;

  // r0 is hardwired in the register file, so a core write to it is no write at all
  assign core_eff = cpu_we && (cpu_waddr != '0);

  // The debug request only ages while it is actually losing to the core
  assign wait_inc = (fsm == ST_RUN) && dbg_req && core_eff;

  sat_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk       (clk),
    .startin_n (startin_n),
    .inc       (wait_inc),
    .at_limit  (wait_at_limit)
  );

  // State register: sequencer state, sweep index and deferred-init flag
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      fsm       <= ST_INIT;
      idx       <= FIRST_IDX;
      init_pend <= 1'b0;
    end else begin
      fsm       <= fsm_next;
      idx       <= idx_next;
      init_pend <= init_pend_next;
    end
  end

  // Next-state logic: sweep progress, forced debug slot and soft_init handling
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    fsm_next       = fsm;
    idx_next       = idx;
    init_pend_next = init_pend;
    case (fsm)
      ST_INIT: begin
        if (idx == LAST_IDX) begin
          fsm_next = ST_RUN;
          idx_next = FIRST_IDX;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      ST_RUN: begin
        if (dbg_req && core_eff && wait_at_limit) begin
          // The forced slot wins; a coincident soft_init is remembered for after it
          fsm_next = ST_DBG;
          if (soft_init) init_pend_next = 1'b1;
        end else if (soft_init) begin
          fsm_next = ST_INIT;
        end
      end
      ST_DBG: begin
        if (soft_init) init_pend_next = 1'b1;
        fsm_next = (soft_init || init_pend) ? ST_INIT : ST_RUN;
      end
      default: fsm_next = ST_INIT;
    endcase
    // Every sweep starts at r1 and consumes any deferred init request
    if (fsm_next == ST_INIT && fsm != ST_INIT) begin
      idx_next       = FIRST_IDX;
      init_pend_next = 1'b0;
    end
  end

  // Output logic: drive the write port from the state and current requests
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = cpu_waddr;
    rf_wdata  = cpu_wdata;
    dbg_gnt   = 1'b0;
    busy      = 1'b0;
    cpu_stall = 1'b1;
    case (fsm)
      ST_INIT: begin
        rf_we    = 1'b1;
        rf_waddr = idx;
        rf_wdata = '0;
        busy     = 1'b1;
      end
      ST_RUN: begin
        cpu_stall = 1'b0;
        if (core_eff) begin
          rf_we = 1'b1;
        end else if (dbg_req) begin
          dbg_gnt  = 1'b1;
          rf_we    = (dbg_addr != '0);
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end
      end
      ST_DBG: begin
        dbg_gnt  = 1'b1;
        rf_we    = (dbg_addr != '0);
        rf_waddr = dbg_addr;
        rf_wdata = dbg_wdata;
      end
      default: ;
    endcase
    // The state flops already hold INIT during reset, so the port itself must be quietened
    if (!startin_n) begin
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      dbg_gnt   = 1'b0;
      busy      = 1'b1;
      cpu_stall = 1'b1;
    end
  end

endmodule
